// File: rtl/ldpc_bit_interleaver_if.sv
// 1-bit Avalon-ST codeword stream in, interleaved stream out, plus error pulse.
// The block itself connects through the slave modport; its stimulus source uses the master modport.
interface ldpc_bit_interleaver_if;
    logic in_startofpacket;
    logic in_endofpacket;
    logic in_valid;
    logic in_ready;
    logic in_in_data;
    logic out_startofpacket;
    logic out_endofpacket;
    logic out_valid;
    logic out_ready;
    logic out_out_data;
    logic err_pulse;

    modport master (
        output in_startofpacket, in_endofpacket, in_valid, in_in_data, out_ready,
        input  in_ready, out_startofpacket, out_endofpacket, out_valid, out_out_data, err_pulse
    );

    modport slave (
        input  in_startofpacket, in_endofpacket, in_valid, in_in_data, out_ready,
        output in_ready, out_startofpacket, out_endofpacket, out_valid, out_out_data, err_pulse
    );
endinterface

// File: rtl/ldpc_bit_interleaver.sv
// Row-write / column-read bit interleaver for one LDPC codeword of ROWS*COLS bits.
// Fills an N-bit buffer in input order, then drains it column-major; malformed packets are dropped.
module ldpc_bit_interleaver #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    ldpc_bit_interleaver_if.slave       st
);

    localparam int          N    = ROWS * COLS;
    localparam int          CW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned R_U  = ROWS;
    localparam int unsigned C_U  = COLS;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   wr_cnt_q;
    logic [CW-1:0]   rd_cnt_q;
    logic [N-1:0]    buf_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_sop_q;
    logic            out_eop_q;
    logic            out_data_q;
    logic            err_q;

    logic            in_xfer_s;
    logic            out_xfer_s;
    logic            fill_bad_s;
    logic            wr_en_s;
    logic [CW-1:0]   wr_addr_s;
    logic [CW-1:0]   rd_cnt_d;
    logic [CW-1:0]   rd_idx_s;

    // Output index k sits in column k/ROWS, row k%ROWS of the row-major buffer.
    function automatic logic [CW-1:0] map_idx(input logic [CW-1:0] k);
        int unsigned kk;
        kk = 32'(k);
        return CW'((kk % R_U) * C_U + (kk / R_U));
    endfunction

    // Handshake strobes, packet-shape check and next read position.
    always_comb begin
        in_xfer_s  = st.in_valid & in_ready_q;
        out_xfer_s = out_valid_q & st.out_ready;
        // A good FILL beat never carries sop, and carries eop exactly on the last bit.
        fill_bad_s = st.in_startofpacket | (st.in_endofpacket != (wr_cnt_q == CNT_LAST));
        if (rd_cnt_q != CNT_LAST) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
        rd_idx_s = map_idx(rd_cnt_d);
        case (state_q)
            IDLE: begin
                wr_en_s   = in_xfer_s & st.in_startofpacket;
                wr_addr_s = CNT_ZERO;
            end
            FILL: begin
                wr_en_s   = in_xfer_s;
                wr_addr_s = wr_cnt_q;
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_addr_s = CNT_ZERO;
            end
        endcase
    end

    // Codeword buffer; contents survive reset and are simply overwritten by the next packet.
    always_ff @(posedge clk_clk) begin
        if (wr_en_s) begin
            buf_q[wr_addr_s] <= st.in_in_data;
        end
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            wr_cnt_q    <= CNT_ZERO;
            rd_cnt_q    <= CNT_ZERO;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_xfer_s && st.in_startofpacket) begin
                        if (st.in_endofpacket) begin
                            err_q <= 1'b1;
                        end else begin
                            wr_cnt_q <= CNT_ONE;
                            state_q  <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (in_xfer_s) begin
                        if (fill_bad_s) begin
                            err_q    <= 1'b1;
                            wr_cnt_q <= CNT_ZERO;
                            state_q  <= IDLE;
                        end else if (wr_cnt_q == CNT_LAST) begin
                            // Bit 0 of the output was written long ago, so buf_q is already valid here.
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            rd_cnt_q    <= CNT_ZERO;
                            out_valid_q <= 1'b1;
                            out_sop_q   <= 1'b1;
                            out_eop_q   <= 1'b0;
                            out_data_q  <= buf_q[map_idx(CNT_ZERO)];
                        end else begin
                            wr_cnt_q <= wr_cnt_q + CNT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (out_xfer_s) begin
                        if (rd_cnt_q == CNT_LAST) begin
                            state_q     <= IDLE;
                            in_ready_q  <= 1'b1;
                            wr_cnt_q    <= CNT_ZERO;
                            rd_cnt_q    <= CNT_ZERO;
                            out_valid_q <= 1'b0;
                            out_sop_q   <= 1'b0;
                            out_eop_q   <= 1'b0;
                            out_data_q  <= 1'b0;
                        end else begin
                            rd_cnt_q   <= rd_cnt_d;
                            out_sop_q  <= 1'b0;
                            out_eop_q  <= (rd_cnt_d == CNT_LAST);
                            out_data_q <= buf_q[rd_idx_s];
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    wr_cnt_q    <= CNT_ZERO;
                    rd_cnt_q    <= CNT_ZERO;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_sop_q   <= 1'b0;
                    out_eop_q   <= 1'b0;
                    out_data_q  <= 1'b0;
                end
            endcase
        end
    end

    assign st.in_ready          = in_ready_q;
    assign st.out_valid         = out_valid_q;
    assign st.out_startofpacket = out_sop_q;
    assign st.out_endofpacket   = out_eop_q;
    assign st.out_out_data      = out_data_q;
    assign st.err_pulse         = err_q;

endmodule

// File: tb/tb_ldpc_bit_interleaver.sv
// Directed bench: a 2x4 instance for the protocol/error cases and a default 8x8 instance for the ramp.
// Inputs change and outputs are sampled on the falling edge.
module tb_ldpc_bit_interleaver;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;

    always #5 clk = ~clk;

    ldpc_bit_interleaver_if ifa ();
    ldpc_bit_interleaver_if ifb ();

    ldpc_bit_interleaver #(.ROWS(2), .COLS(4)) u_dut_a (
        .clk_clk       (clk),
        .reset_reset_n (rst_a_n),
        .st            (ifa)
    );

    ldpc_bit_interleaver u_dut_b (
        .clk_clk       (clk),
        .reset_reset_n (rst_b_n),
        .st            (ifb)
    );

    int checks_n = 0;
    int fails_n  = 0;

    int err_seen_a   = 0;
    int valid_seen_a = 0;
    int err_run_a    = 0;
    int err_run_max  = 0;

    // Running tallies of the small instance's error pulses and valid cycles.
    always @(negedge clk) begin
        if (ifa.err_pulse === 1'b1) begin
            err_seen_a++;
            err_run_a++;
            if (err_run_a > err_run_max) err_run_max = err_run_a;
        end else begin
            err_run_a = 0;
        end
        if (ifa.out_valid === 1'b1) valid_seen_a++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_n++;
        if (obs !== exp) begin
            fails_n++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input int sel, input logic v, input logic s, input logic e, input logic d);
        if (sel == 0) begin
            ifa.in_valid = v; ifa.in_startofpacket = s; ifa.in_endofpacket = e; ifa.in_in_data = d;
        end else begin
            ifb.in_valid = v; ifb.in_startofpacket = s; ifb.in_endofpacket = e; ifb.in_in_data = d;
        end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 0) ifa.out_ready = r;
        else          ifb.out_ready = r;
    endtask

    // {in_ready, err_pulse, out_valid, out_sop, out_eop, out_data}
    function automatic logic [5:0] obs_out(input int sel);
        if (sel == 0)
            return {ifa.in_ready, ifa.err_pulse, ifa.out_valid, ifa.out_startofpacket,
                    ifa.out_endofpacket, ifa.out_out_data};
        else
            return {ifb.in_ready, ifb.err_pulse, ifb.out_valid, ifb.out_startofpacket,
                    ifb.out_endofpacket, ifb.out_out_data};
    endfunction

    task automatic send_pkt(input int sel, input logic [63:0] bits, input int n,
                            input logic [63:0] sop_m, input logic [63:0] eop_m, output int rdy_bad);
        logic [5:0] o;
        rdy_bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = obs_out(sel);
            if (o[5] !== 1'b1) rdy_bad++;
            drive_in(sel, 1'b1, sop_m[i], eop_m[i], bits[i]);
        end
    endtask

    task automatic idle_cycles(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_in(sel, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic collect(input int sel, input int n, input bit toggle, output logic [63:0] got,
                           output int first_ok, output int span, output int bad_flag,
                           output int bad_stall, output int bad_rdy, output logic [5:0] done_o);
        logic [5:0] o;
        logic [5:0] prev;
        bit stalled;
        logic rdy;
        int got_n;
        int cyc;
        got = 64'h0; first_ok = 0; bad_flag = 0; bad_stall = 0; bad_rdy = 0;
        stalled = 1'b0; prev = 6'h00; got_n = 0; cyc = 0;
        while (got_n < n && cyc < 400) begin
            @(negedge clk);
            o = obs_out(sel);
            if (cyc == 0) begin
                drive_in(sel, 1'b0, 1'b0, 1'b0, 1'b0);
                first_ok = (o[3] === 1'b1) ? 1 : 0;
            end
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (stalled && (o[3:0] !== prev[3:0])) bad_stall++;
            if (o[3] === 1'b1 && o[5] !== 1'b0) bad_rdy++;
            if (o[3] === 1'b1 && rdy) begin
                got[got_n] = o[0];
                if (o[2] !== (got_n == 0))     bad_flag++;
                if (o[1] !== (got_n == n - 1)) bad_flag++;
                got_n++;
            end else if (o[3] !== 1'b1) begin
                if (o[2] !== 1'b0 || o[1] !== 1'b0) bad_flag++;
            end
            stalled = (o[3] === 1'b1) && !rdy;
            prev = o;
            set_ready(sel, rdy);
            cyc++;
        end
        span = cyc;
        check_eq("collect_count", 64'(got_n), 64'(n));
        @(negedge clk);
        done_o = obs_out(sel);
    endtask

    // Full check of one good packet through the 2x4 instance.
    task automatic good_pkt_a(input string tag, input bit toggle);
        logic [63:0] got;
        logic [5:0]  done_o;
        int rb, first_ok, span, bf, bs, br;
        send_pkt(0, 64'h4D, 8, 64'h01, 64'h80, rb);
        collect(0, 8, toggle, got, first_ok, span, bf, bs, br, done_o);
        check_eq({tag, "_in_ready_fill"}, 64'(rb), 64'd0);
        check_eq({tag, "_data"}, got, 64'h71);
        check_eq({tag, "_latency"}, 64'(first_ok), 64'd1);
        check_eq({tag, "_span"}, 64'(span), toggle ? 64'd15 : 64'd8);
        check_eq({tag, "_sop_eop"}, 64'(bf), 64'd0);
        check_eq({tag, "_stall_stable"}, 64'(bs), 64'd0);
        check_eq({tag, "_no_ready_drain"}, 64'(br), 64'd0);
        check_eq({tag, "_back_to_idle"}, 64'({done_o[5], done_o[3]}), 64'b10);
    endtask

    initial begin
        logic [5:0]  o;
        logic [63:0] ramp;
        logic [63:0] ramp_exp;
        logic [63:0] got;
        logic [5:0]  done_o;
        int rb, first_ok, span, bf, bs, br;
        int e0, v0;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        drive_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_in(1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_ready(0, 1'b0);
        set_ready(1, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("reset_state_a", 64'(obs_out(0)), 64'h20);
        check_eq("reset_state_b", 64'(obs_out(1)), 64'h20);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Baseline: full-rate drain, then alternating backpressure.
        good_pkt_a("pkt_full_rate", 1'b0);
        good_pkt_a("pkt_toggle", 1'b1);

        // Early eop at bit 5.
        e0 = err_seen_a; v0 = valid_seen_a;
        send_pkt(0, 64'h4D, 6, 64'h01, 64'h20, rb);
        idle_cycles(0, 4);
        check_eq("early_eop_err", 64'(err_seen_a - e0), 64'd1);
        check_eq("early_eop_no_out", 64'(valid_seen_a - v0), 64'd0);
        good_pkt_a("after_early_eop", 1'b0);

        // sop repeated at bit 3; the tail arrives in IDLE without sop and is dropped.
        e0 = err_seen_a; v0 = valid_seen_a;
        send_pkt(0, 64'h4D, 8, 64'h09, 64'h80, rb);
        idle_cycles(0, 4);
        check_eq("resop_err", 64'(err_seen_a - e0), 64'd1);
        check_eq("resop_no_out", 64'(valid_seen_a - v0), 64'd0);

        // Single-bit packet.
        e0 = err_seen_a; v0 = valid_seen_a;
        send_pkt(0, 64'h01, 1, 64'h01, 64'h01, rb);
        idle_cycles(0, 3);
        check_eq("one_bit_err", 64'(err_seen_a - e0), 64'd1);
        check_eq("one_bit_no_out", 64'(valid_seen_a - v0), 64'd0);

        // Reset during drain at read count 3.
        e0 = err_seen_a;
        send_pkt(0, 64'h4D, 8, 64'h01, 64'h80, rb);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) drive_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
            set_ready(0, 1'b1);
        end
        @(negedge clk);
        o = obs_out(0);
        check_eq("drain_k3", 64'(o[3:0]), 64'b1000);
        rst_a_n = 1'b0;
        @(negedge clk);
        rst_a_n = 1'b1;
        check_eq("rst_mid_drain", 64'(obs_out(0)), 64'h20);
        idle_cycles(0, 2);
        check_eq("rst_no_err", 64'(err_seen_a - e0), 64'd0);
        good_pkt_a("after_reset", 1'b0);

        // Default 8x8 ramp, two packets.
        for (int i = 0; i < 64; i++) ramp[i] = ((i % 3) == 0);
        for (int k = 0; k < 64; k++) ramp_exp[k] = ramp[(k % 8) * 8 + k / 8];
        for (int p = 0; p < 2; p++) begin
            send_pkt(1, ramp, 64, 64'h1, 64'h8000_0000_0000_0000, rb);
            collect(1, 64, 1'b0, got, first_ok, span, bf, bs, br, done_o);
            check_eq("ramp_in_ready", 64'(rb), 64'd0);
            check_eq("ramp_data", got, ramp_exp);
            check_eq("ramp_latency", 64'(first_ok), 64'd1);
            check_eq("ramp_span", 64'(span), 64'd64);
            check_eq("ramp_sop_eop", 64'(bf), 64'd0);
            check_eq("ramp_back_to_idle", 64'({done_o[5], done_o[3]}), 64'b10);
        end

        check_eq("err_pulse_width", 64'(err_run_max), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
